// File: rtl/cw_keying_envelope.sv
// Shaped CW keying envelope: ramps a signed amplitude linearly between 0 and
// iS_amplitude in response to an asynchronous active-low key, suppressing key clicks.
module cw_keying_envelope #(
   parameter int DATA_WIDTH = 16,
   parameter int RAMP_BITS  = 8,
   parameter int STEP_DIV   = 16
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_key_n,
   input  logic signed [DATA_WIDTH-1:0] iS_amplitude,
   output logic signed [DATA_WIDTH-1:0] oS_output
);

   localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int PW    = DATA_WIDTH + RAMP_BITS + 1;
   localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(STEP_DIV - 1);
   localparam logic [RAMP_BITS:0] ENV_FULL = {1'b1, {RAMP_BITS{1'b0}}};

   logic                         keyMeta_q;
   logic                         keySync_q;
   logic [DIV_W-1:0]             div_q, div_d;
   logic [RAMP_BITS:0]           env_q, env_d;
   logic signed [DATA_WIDTH-1:0] out_q, out_d;

   logic                         keyChange;
   logic                         stepStrobe;
   logic signed [PW-1:0]         ampExt;
   logic signed [PW-1:0]         envExt;
   logic signed [PW-1:0]         product;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         keyMeta_q <= 1'b1;
         keySync_q <= 1'b1;
         div_q     <= '0;
         env_q     <= '0;
         out_q     <= '0;
      end else begin
         keyMeta_q <= i_key_n;
         keySync_q <= keyMeta_q;
         div_q     <= div_d;
         env_q     <= env_d;
         out_q     <= out_d;
      end
   end

   // Divider restarts as the synchronized key is about to change, so the first
   // envelope step lands exactly STEP_DIV clocks after key_s toggles.
   always_comb begin
      keyChange  = (keyMeta_q != keySync_q);
      stepStrobe = !keyChange && (div_q == DIV_LAST);
      div_d      = (keyChange || stepStrobe) ? '0 : div_q + 1'b1;
      env_d      = env_q;
      if (stepStrobe) begin
         if (!keySync_q && (env_q != ENV_FULL)) begin
            env_d = env_q + 1'b1;
         end else if (keySync_q && (env_q != '0)) begin
            env_d = env_q - 1'b1;
         end
      end
   end

   // Full-precision signed product; env is zero-extended so it stays non-negative.
   always_comb begin
      ampExt  = {{(PW-DATA_WIDTH){iS_amplitude[DATA_WIDTH-1]}}, iS_amplitude};
      envExt  = {{(PW-RAMP_BITS-1){1'b0}}, env_q};
      product = ampExt * envExt;
      out_d   = DATA_WIDTH'(product >>> RAMP_BITS);
   end

   assign oS_output = out_q;

endmodule

// File: tb/tb_cw_keying_envelope.sv
// Directed self-checking bench for cw_keying_envelope: ramp timing, saturation,
// partial pulses, negative amplitude rounding and asynchronous reset.
module tb_cw_keying_envelope;

   logic               clk = 1'b0;
   logic               reset;
   logic               keyN;
   logic signed [15:0] amplitude;
   logic signed [15:0] dutOut;

   int checks = 0;
   int errors = 0;

   cw_keying_envelope #(
      .DATA_WIDTH(16),
      .RAMP_BITS (8),
      .STEP_DIV  (16)
   ) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_key_n     (keyN),
      .iS_amplitude(amplitude),
      .oS_output   (dutOut)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic signed [15:0] expected);
      checks++;
      assert (dutOut === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed %0d expected %0d", tag, dutOut, expected);
      end
   endtask

   task automatic checkFlag(input string tag, input logic observed);
      checks++;
      assert (observed === 1'b1) else begin
         errors++;
         $error("[TB] FAIL %s observed %0b expected 1", tag, observed);
      end
   endtask

   task automatic applyStimulus(input logic key, input logic signed [15:0] amp);
      keyN      = key;
      amplitude = amp;
   endtask

   // Inputs are driven and outputs sampled 1 time unit after each rising edge.
   task automatic stepCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic signed [15:0] prev;
      logic               ok;
      logic               smooth;
      logic signed [15:0] peak;
      int                 diff;

      reset = 1'b1;
      applyStimulus(1'b1, 16'sd32000);
      #2;
      checkOutput("resetState", 16'sd0);
      stepCycles(3);
      checkOutput("resetHeld", 16'sd0);
      reset = 1'b0;

      $display("[TB] key up idle");
      ok = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         stepCycles(1);
         if (dutOut !== 16'sd0) ok = 1'b0;
      end
      checkFlag("keyUpIdleAllZero", ok);
      checkOutput("keyUpIdleEnd", 16'sd0);

      $display("[TB] full rise");
      applyStimulus(1'b0, 16'sd32000);
      prev = 16'sd0;
      ok   = 1'b1;
      for (int k = 1; k <= 4099; k++) begin
         stepCycles(1);
         if (dutOut < prev) ok = 1'b0;
         prev = dutOut;
         if (k == 18)   checkOutput("riseFirstStepLatency", 16'sd0);
         if (k == 19)   checkOutput("riseFirstStep", 16'sd125);
         if (k == 2050) checkOutput("riseEnv127", 16'sd15875);
         if (k == 2051) checkOutput("riseEnv128", 16'sd16000);
         if (k == 4098) checkOutput("riseEnv255", 16'sd31875);
         if (k == 4099) checkOutput("riseFull", 16'sd32000);
      end
      checkFlag("riseMonotonic", ok);
      stepCycles(200);
      checkOutput("fullHold", 16'sd32000);
      applyStimulus(1'b0, 16'sd1000);
      stepCycles(1);
      checkOutput("ampLiveChange", 16'sd1000);
      applyStimulus(1'b0, 16'sd32000);
      stepCycles(1);
      checkOutput("ampRestore", 16'sd32000);

      $display("[TB] full fall");
      applyStimulus(1'b1, 16'sd32000);
      prev = 16'sd32000;
      ok   = 1'b1;
      for (int k = 1; k <= 4099; k++) begin
         stepCycles(1);
         if (dutOut > prev) ok = 1'b0;
         prev = dutOut;
         if (k == 18)   checkOutput("fallFirstStepLatency", 16'sd32000);
         if (k == 19)   checkOutput("fallFirstStep", 16'sd31875);
         if (k == 4098) checkOutput("fallEnv1", 16'sd125);
         if (k == 4099) checkOutput("fallZero", 16'sd0);
      end
      checkFlag("fallMonotonic", ok);
      stepCycles(500);
      checkOutput("zeroHoldNoUnderflow", 16'sd0);

      $display("[TB] short pulse");
      applyStimulus(1'b0, 16'sd32000);
      prev   = 16'sd0;
      peak   = 16'sd0;
      smooth = 1'b1;
      for (int k = 1; k <= 2100; k++) begin
         stepCycles(1);
         diff = int'(dutOut) - int'(prev);
         if (diff > 125 || diff < -125) smooth = 1'b0;
         if (dutOut > peak) peak = dutOut;
         prev = dutOut;
         if (k == 1000) applyStimulus(1'b1, 16'sd32000);
         if (k == 1003) checkOutput("pulsePeakValue", 16'sd7750);
         if (k == 1994) checkOutput("pulseDecayEnv1", 16'sd125);
         if (k == 1995) checkOutput("pulseDecayZero", 16'sd0);
      end
      checkFlag("pulseNoStep", smooth);
      checkOutput("pulseEnd", 16'sd0);
      prev = dutOut;
      checks++;
      assert (peak === 16'sd7750) else begin
         errors++;
         $error("[TB] FAIL pulsePeakMax observed %0d expected 7750", peak);
      end

      $display("[TB] negative amplitude");
      applyStimulus(1'b0, -16'sd32000);
      stepCycles(4200);
      checkOutput("negFull", -16'sd32000);
      applyStimulus(1'b1, -16'sd32000);
      for (int k = 1; k <= 4100; k++) begin
         stepCycles(1);
         if (k == 4085) begin
            checkOutput("negEnv1", -16'sd125);
            applyStimulus(1'b1, -16'sd1);
         end
         if (k == 4086) checkOutput("negFloorRounding", -16'sd1);
         if (k == 4100) checkOutput("negZero", 16'sd0);
      end

      $display("[TB] async reset mid-ramp");
      applyStimulus(1'b0, 16'sd32000);
      stepCycles(1605);
      checkOutput("preResetEnv100", 16'sd12500);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("asyncResetImmediate", 16'sd0);
      stepCycles(3);
      checkOutput("asyncResetHeld", 16'sd0);
      reset = 1'b0;
      for (int k = 1; k <= 19; k++) begin
         stepCycles(1);
         if (k == 17) checkOutput("restartFlat", 16'sd0);
         if (k == 18) checkOutput("restartLatency", 16'sd0);
         if (k == 19) checkOutput("restartFromZero", 16'sd125);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
